// File: rtl/sbio_pkg.sv
// Shared definitions for the sbio serial link: framing codes, TX state encoding and sizing helpers.
package sbio_pkg;

    localparam int unsigned SBIO_START_CODE = 1;

    // Header codes identifying the producer of a TX frame.
    localparam logic [1:0] TX_SOURCE_SCAN  = 2'd0;
    localparam logic [1:0] TX_SOURCE_READ  = 2'd1;
    localparam logic [1:0] TX_SOURCE_OUT   = 2'd2;
    localparam logic [1:0] TX_SOURCE_WRITE = 2'd3;

    // Start-bit codes found at the head of an RX frame.
    localparam logic [1:0] RX_START_IDLE  = 2'd0;
    localparam logic [1:0] RX_START_REPLY = 2'd1;
    localparam logic [1:0] RX_START_EVENT = 2'd2;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HEADER  = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;

    function automatic int unsigned word_size(input int unsigned io_bits,
                                              input int unsigned payload_cycles);
        return io_bits * payload_cycles;
    endfunction

endpackage

// File: rtl/sbio_rr_arbiter.sv
// One-hot arbiter over a request vector; round-robin from a rotating pointer or fixed
// lowest-index priority. The pointer advances past the winner only when the grant is accepted.
module sbio_rr_arbiter #(
    parameter int unsigned NUM_SOURCES = 3,
    parameter int unsigned ROUND_ROBIN = 1,
    localparam int unsigned PTR_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_SOURCES-1:0] req,
    input  logic                   accept,
    output logic [NUM_SOURCES-1:0] grant
);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] grant_idx;
    logic             found;

    function automatic logic [PTR_W-1:0] slot(input logic [PTR_W-1:0] base,
                                              input int unsigned k);
        int unsigned pos;
        pos = (ROUND_ROBIN != 0) ? (32'(base) + k) % NUM_SOURCES : k;
        return PTR_W'(pos);
    endfunction

    // NOTE: every variable written in always_comb gets a default first, so no path leaves it latched.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int unsigned k = 0; k < NUM_SOURCES; k++) begin
            if (!found && req[slot(ptr, k)]) begin
                grant[slot(ptr, k)] = 1'b1;
                grant_idx           = slot(ptr, k);
                found               = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (accept && found) begin
            ptr <= (grant_idx == PTR_W'(NUM_SOURCES - 1)) ? '0 : grant_idx + PTR_W'(1);
        end
    end

endmodule

// File: rtl/sbio_tx_scheduler.sv
// Multi-source sbio transmitter: arbitrates pending producers, limits outstanding reply-expecting
// frames with a credit counter, and serialises start code, header and LSB-first payload onto tx_pins.
module sbio_tx_scheduler
    import sbio_pkg::*;
#(
    parameter int unsigned             IO_BITS         = 2,
    parameter int unsigned             PAYLOAD_CYCLES  = 8,
    parameter int unsigned             NUM_SOURCES     = 3,
    parameter logic [NUM_SOURCES-1:0]  REPLY_MASK      = 3'b010,
    parameter int unsigned             MAX_OUTSTANDING = 2,
    parameter int unsigned             ROUND_ROBIN     = 1,
    parameter int unsigned             START_CODE      = SBIO_START_CODE,
    localparam int unsigned            WORD_SIZE       = word_size(IO_BITS, PAYLOAD_CYCLES),
    localparam int unsigned            OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_SOURCES-1:0]           src_valid,
    input  logic [NUM_SOURCES*IO_BITS-1:0]   src_header,
    input  logic [NUM_SOURCES*WORD_SIZE-1:0] src_data,
    output logic [NUM_SOURCES-1:0]           src_ready,
    input  logic                             reply_done,
    output logic [IO_BITS-1:0]               tx_pins,
    output logic                             busy,
    output logic                             frame_done,
    output logic [OUT_W-1:0]                 outstanding,
    output logic                             credit_err
);

    localparam int unsigned CNT_W = (PAYLOAD_CYCLES > 1) ? $clog2(PAYLOAD_CYCLES) : 1;

    logic [1:0]               state;
    logic [CNT_W-1:0]         cnt;
    logic [IO_BITS-1:0]       header_q;
    logic [WORD_SIZE-1:0]     shift_q;

    logic                     at_limit;
    logic [NUM_SOURCES-1:0]   eligible;
    logic [NUM_SOURCES-1:0]   grant;
    logic                     start;
    logic                     last_cycle;
    logic                     credit_take;
    logic                     credit_return;
    logic [IO_BITS-1:0]       sel_header;
    logic [WORD_SIZE-1:0]     sel_data;

    // Reply sources sit out while every credit is in use; a returned credit counts from the next cycle.
    assign at_limit   = (outstanding == OUT_W'(MAX_OUTSTANDING));
    assign eligible   = src_valid & ~(REPLY_MASK & {NUM_SOURCES{at_limit}});
    // Gating with reset keeps src_ready and the start code quiet while reset is held.
    assign start      = (state == ST_IDLE) && reset && (|eligible);
    assign last_cycle = (cnt == CNT_W'(PAYLOAD_CYCLES - 1));
    assign src_ready  = start ? grant : '0;

    sbio_rr_arbiter #(
        .NUM_SOURCES (NUM_SOURCES),
        .ROUND_ROBIN (ROUND_ROBIN)
    ) u_arbiter (
        .clk    (clk),
        .reset  (reset),
        .req    (eligible),
        .accept (start),
        .grant  (grant)
    );

    always_comb begin
        sel_header = '0;
        sel_data   = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (grant[i]) begin
                sel_header = src_header[i*IO_BITS +: IO_BITS];
                sel_data   = src_data[i*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            header_q <= '0;
            shift_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        header_q <= sel_header;
                        shift_q  <= sel_data;
                        state    <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    cnt   <= '0;
                    state <= ST_PAYLOAD;
                end
                ST_PAYLOAD: begin
                    shift_q <= shift_q >> IO_BITS;
                    if (last_cycle) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        tx_pins    = '0;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) tx_pins = IO_BITS'(START_CODE);
            end
            ST_HEADER: begin
                tx_pins = header_q;
                busy    = 1'b1;
            end
            ST_PAYLOAD: begin
                tx_pins    = shift_q[IO_BITS-1:0];
                busy       = 1'b1;
                frame_done = last_cycle;
            end
            default: ;
        endcase
    end

    // A reply at zero cannot answer a grant issued in the same cycle, so that grant still takes a credit.
    assign credit_take   = start && (|(grant & REPLY_MASK));
    assign credit_return = reply_done && (outstanding != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outstanding <= '0;
            credit_err  <= 1'b0;
        end else begin
            if (credit_take && !credit_return) begin
                outstanding <= outstanding + OUT_W'(1);
            end else if (!credit_take && credit_return) begin
                outstanding <= outstanding - OUT_W'(1);
            end
            if (reply_done && (outstanding == '0)) begin
                credit_err <= 1'b1;
            end
        end
    end

endmodule
